// File: rtl/fp_add_normalize.sv
// fp_add_normalize: post-adder normalization and IEEE-754 single packing.
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid / in_ready       bundle handshake (accepted only in IDLE)
//   in_sum, in_co             24-bit mantissa sum and adder carry-out
//   in_exp, in_sign           biased exponent (1..254) and result sign
//   out_valid / out_ready     result handshake (held in DONE until taken)
//   out_result                {sign, exp[7:0], frac[22:0]}
//   out_ovf, out_unf          overflow-to-infinity, denormal result
module fp_add_normalize #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_sum,
  input  logic              in_co,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_ovf,
  output logic              out_unf
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_n;
  logic [MANT_W-1:0] mant_r, mant_n;
  logic [EXP_W-1:0] exp_r, exp_n, exp_inc;
  logic sign_r, sign_n, co_r, co_n, ovf_r, ovf_n, unf_r, unf_n;
  logic [31:0] result_r, result_n;
  assign exp_inc = exp_r + 1'b1;
  // state resets to IDLE, so gate with rst to keep in_ready low during reset
  assign in_ready = rst && state == IDLE;
  assign out_valid = state == DONE;
  assign out_result = result_r;
  assign out_ovf = ovf_r;
  assign out_unf = unf_r;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mant_r <= '0;
      exp_r <= '0;
      sign_r <= 1'b0;
      co_r <= 1'b0;
      result_r <= '0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      state <= state_n;
      mant_r <= mant_n;
      exp_r <= exp_n;
      sign_r <= sign_n;
      co_r <= co_n;
      result_r <= result_n;
      ovf_r <= ovf_n;
      unf_r <= unf_n;
    end
  end
  always_comb begin
    state_n = state;
    mant_n = mant_r;
    exp_n = exp_r;
    sign_n = sign_r;
    co_n = co_r;
    result_n = result_r;
    ovf_n = ovf_r;
    unf_n = unf_r;
    case (state)
      IDLE: if (in_valid) begin
        state_n = NORM;
        mant_n = in_sum;
        exp_n = in_exp;
        sign_n = in_sign;
        co_n = in_co;
      end
      NORM: begin
        if (co_r) begin
          // carry-out: one truncating right shift, may overflow to infinity
          state_n = DONE;
          co_n = 1'b0;
          mant_n = {1'b1, mant_r[MANT_W-1:1]};
          exp_n = exp_inc;
          ovf_n = &exp_inc;
          result_n = &exp_inc ? {sign_r, 8'hFF, 23'd0} : {sign_r, exp_inc, mant_r[MANT_W-1:1]};
        end else if (mant_r == '0) begin
          state_n = DONE;
          result_n = '0;
        end else if (mant_r[MANT_W-1]) begin
          state_n = DONE;
          result_n = {sign_r, exp_r, mant_r[MANT_W-2:0]};
        end else if (exp_r == EXP_W'(1)) begin
          // exponent floor reached without a leading one: denormal
          state_n = DONE;
          unf_n = 1'b1;
          result_n = {sign_r, 8'h00, mant_r[MANT_W-2:0]};
        end else begin
          mant_n = mant_r << 1;
          exp_n = exp_r - 1'b1;
        end
      end
      DONE: if (out_ready) begin
        state_n = IDLE;
        ovf_n = 1'b0;
        unf_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_add_normalize.sv
// tb_fp_add_normalize: randomized and directed checks against an arithmetic reference model.
module tb_fp_add_normalize;
  logic clk = 0, rst = 0, in_valid = 0, in_co = 0, in_sign = 0, out_ready = 0;
  logic [23:0] in_sum = 0;
  logic [7:0] in_exp = 8'd1;
  logic in_ready, out_valid, out_ovf, out_unf;
  logic [31:0] out_result;
  int checks = 0, errors = 0;

  fp_add_normalize dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_co(in_co), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  // Reference: value = (co*2^24 + sum) * 2^(exp-bias); normalize so the
  // leading one lands at bit 23 while the exponent stays >= 1, truncating.
  task automatic model(input logic [23:0] s, input logic co, input logic [7:0] e, input logic sg,
                       output logic [31:0] r, output logic ovf, output logic unf, output int lat);
    longint m;
    int ev, msb, sh;
    ovf = 0; unf = 0; lat = 1; ev = int'(e);
    if (co) begin
      m = (longint'(s) + (longint'(1) << 24)) / 2;
      ev = ev + 1;
      if (ev == 255) begin r = {sg, 8'hFF, 23'd0}; ovf = 1; end
      else r = {sg, ev[7:0], m[22:0]};
    end else if (s == 0) begin
      r = 32'd0;
    end else begin
      msb = 0;
      for (int b = 0; b < 24; b++) if (s[b]) msb = b;
      sh = (23 - msb) < (ev - 1) ? (23 - msb) : (ev - 1);
      m = longint'(s) * (longint'(1) << sh);
      ev = ev - sh;
      lat = sh + 1;
      if (m >= (longint'(1) << 23)) r = {sg, ev[7:0], m[22:0]};
      else begin r = {sg, 8'd0, m[22:0]}; unf = 1; end
    end
  endtask

  task automatic run(input logic [23:0] s, input logic co, input logic [7:0] e, input logic sg,
                     output int lat, output logic [31:0] r, output logic ov, output logic un);
    in_sum = s; in_co = co; in_exp = e; in_sign = sg; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 40);
    r = out_result; ov = out_ovf; un = out_unf;
  endtask

  task automatic take;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({in_ready, out_valid, out_ovf, out_unf} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {in_ready, out_valid, out_ovf, out_unf}); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", out_result); end
    rst = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_directed;
    logic [23:0] ds[6] = '{24'h800000, 24'h000000, 24'h000001, 24'h100000, 24'h400000, 24'h000000};
    logic dc[6] = '{0, 1, 0, 0, 1, 0};
    logic [7:0] de[6] = '{127, 127, 127, 2, 254, 127};
    logic dsg[6] = '{0, 1, 0, 0, 0, 1};
    logic [31:0] dr[6] = '{32'h3F800000, 32'hC0000000, 32'h34000000, 32'h00200000, 32'h7F800000, 32'h00000000};
    int dl[6] = '{1, 1, 24, 2, 1, 1};
    logic dov[6] = '{0, 0, 0, 0, 1, 0};
    logic dun[6] = '{0, 0, 0, 1, 0, 0};
    int lat; logic [31:0] r; logic ov, un;
    for (int i = 0; i < 6; i++) begin
      run(ds[i], dc[i], de[i], dsg[i], lat, r, ov, un);
      checks++; if (r !== dr[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, r, dr[i]); end
      checks++; if (lat !== dl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, dl[i]); end
      checks++; if ({ov, un} !== {dov[i], dun[i]}) begin errors++; $display("FAIL dir%0d_flags got %b want %b", i, {ov, un}, {dov[i], dun[i]}); end
      take();
      checks++; if ({out_valid, out_ovf, out_unf, in_ready} !== 4'b0001) begin errors++; $display("FAIL dir%0d_after got %b want 0001", i, {out_valid, out_ovf, out_unf, in_ready}); end
    end
  endtask

  task automatic test_random;
    logic [23:0] s; logic co, sg; logic [7:0] e;
    logic [31:0] er, r; logic eo, eu, ov, un; int el, lat;
    for (int i = 0; i < 60; i++) begin
      s = 24'($urandom_range(0, 24'hFFFFFF) >> $urandom_range(0, 24));
      co = $urandom_range(0, 3) == 0;
      e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 4)) : ($urandom_range(0, 7) == 0) ? 8'd254 : 8'($urandom_range(1, 254));
      sg = 1'($urandom_range(0, 1));
      model(s, co, e, sg, er, eo, eu, el);
      run(s, co, e, sg, lat, r, ov, un);
      checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_result s=%h co=%b e=%0d got %h want %h", i, s, co, e, r, er); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, el); end
      checks++; if ({ov, un} !== {eo, eu}) begin errors++; $display("FAIL rnd%0d_flags got %b want %b", i, {ov, un}, {eo, eu}); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || out_result !== er) begin errors++; $display("FAIL rnd%0d_hold got vld=%b %h want 1 %h", i, out_valid, out_result, er); end
      take();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] er, r; logic eo, eu, ov, un; int el, lat;
    model(24'h123456, 1'b0, 8'd100, 1'b1, er, eo, eu, el);
    run(24'h123456, 1'b0, 8'd100, 1'b1, lat, r, ov, un);
    checks++; if (r !== er || lat !== el) begin errors++; $display("FAIL bp_result got %h/%0d want %h/%0d", r, lat, er, el); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_sum = 24'($urandom); in_co = 1'($urandom); in_exp = 8'($urandom_range(1, 254));
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== er || {out_ovf, out_unf} !== {eo, eu}) begin
        errors++; $display("FAIL bp_hold%0d got vld=%b rdy=%b %h want 1 0 %h", i, out_valid, in_ready, out_result, er);
      end
    end
    in_valid = 0;
    take();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_ignored got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] er, r; logic eo, eu, ov, un; int el, lat, seen;
    in_sum = 24'h000001; in_co = 0; in_exp = 8'd127; in_sign = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got vld=%b rdy=%b want 0 0", out_valid, in_ready); end
    rst = 0;
    #1;
    checks++; if ({in_ready, out_valid, out_ovf, out_unf} !== 4'b0 || out_result !== 32'd0) begin errors++; $display("FAIL mid_reset got %b %h want 0000 00000000", {in_ready, out_valid, out_ovf, out_unf}, out_result); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_abort got valid_cycles=%0d rdy=%b want 0 1", seen, in_ready); end
    model(24'h00F000, 1'b0, 8'd30, 1'b1, er, eo, eu, el);
    run(24'h00F000, 1'b0, 8'd30, 1'b1, lat, r, ov, un);
    checks++; if (r !== er || lat !== el || {ov, un} !== {eo, eu}) begin errors++; $display("FAIL mid_fresh got %h/%0d want %h/%0d", r, lat, er, el); end
    take();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
